dma_itcm_icb_arbiter: RTL
=========================

Name: dma_itcm_icb_arbiter

Overview:
- Two-master ICB arbiter that shares the ITCM ICB slave port between the E203 core (LSU/IFU path) and the DMA engine.
- Arbitrates the command channel with core priority plus a DMA anti-starvation override.
- Locks the grant until the command handshake completes.
- Routes in-order responses back to the owning master using an outstanding-ID FIFO.
- Sits between the core's ITCM ICB and the DMA's memory ICB, in front of the ITCM controller.

Parameters:
- AW, 16, ICB address width in bits.
- DW, 64, data width in bits; mask width is DW/8.
- OTF_DEPTH, 2, maximum number of outstanding commands; a power of 2, at least 1.
- STARVE_MAX, 8, number of consecutive DMA-waiting cycles that triggers DMA priority; at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_icb_cmd_valid / core_icb_cmd_ready  in / out  1  core command handshake
- core_icb_cmd_addr  in  AW  core address
- core_icb_cmd_read  in  1  1 = read, 0 = write
- core_icb_cmd_wdata  in  DW  core write data
- core_icb_cmd_wmask  in  DW/8  core byte mask
- core_icb_rsp_valid / core_icb_rsp_ready  out / in  1  core response handshake
- core_icb_rsp_err  out  1  core response error
- core_icb_rsp_rdata  out  DW  core read data
- dma_icb_*  same set as core_icb_*, same directions and widths, for the DMA master
- itcm_icb_cmd_valid / itcm_icb_cmd_ready  out / in  1  slave command handshake
- itcm_icb_cmd_addr  out  AW  slave address
- itcm_icb_cmd_read  out  1  slave read/write
- itcm_icb_cmd_wdata  out  DW  slave write data
- itcm_icb_cmd_wmask  out  DW/8  slave byte mask
- itcm_icb_rsp_valid / itcm_icb_rsp_ready  in / out  1  slave response handshake
- itcm_icb_rsp_err  in  1  slave response error
- itcm_icb_rsp_rdata  in  DW  slave read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = ARB, lock_id = 0, starve_cnt = 0.
  - FIFO empty: count = 0, wr_ptr = rd_ptr = 0.
  - All valid and ready outputs are 0.
- Command path is combinational: zero added latency. Each cmd field is muxed from the granted master.
- Grant selection in state ARB:
  - Default: core wins if core valid.
  - DMA wins if DMA valid and core not valid.
  - DMA wins if DMA valid and starve_cnt == STARVE_MAX (override).
- FIFO-full gating:
  - When count == OTF_DEPTH: itcm_icb_cmd_valid = 0 and both cmd_ready = 0.
  - A response pop in the same cycle does not unblock the cycle; the next command issues one cycle later.
- Ready routing: only the granted master sees itcm_icb_cmd_ready; the other master's cmd_ready = 0.
- State machine:
  - ARB -> LOCK when the granted valid is presented and itcm_icb_cmd_ready = 0. lock_id records the grant.
  - LOCK: grant is forced to lock_id regardless of other requests. LOCK -> ARB on the command handshake.
  - The same-cycle handshake in ARB stays in ARB.
- Push: on the itcm command handshake, push the master ID (0 = core, 1 = DMA) at wr_ptr; pointers wrap modulo OTF_DEPTH.
- Response routing:
  - The head ID selects the destination master. rsp_valid, err and rdata go only to that master.
  - itcm_icb_rsp_ready = that master's rsp_ready.
  - The other master's rsp_valid = 0.
- Pop on the itcm response handshake. Push and pop in the same cycle leave count unchanged.
- FIFO empty: itcm_icb_rsp_ready = 0 and both master rsp_valid = 0. A stray slave response is ignored.
- starve_cnt:
  - Clears on a DMA command handshake, or when dma_icb_cmd_valid = 0.
  - Otherwise increments each cycle, saturating at STARVE_MAX.
  - The override lasts exactly one accepted DMA command.
- Write and read responses are treated identically; err passes through unmodified.

Optional Feature:
- Macro: DMA_ITCM_ARB_STAT_EN.
- When defined, adds these ports:
  - stat_clr  in  1  clears all counters next cycle.
  - stat_core_cnt  out  32  accepted core commands.
  - stat_dma_cnt  out  32  accepted DMA commands.
  - stat_conflict_cnt  out  32  cycles with both cmd_valid high.
- Counters reset to 0, wrap at 2^32, and stat_clr has priority over increment.
- When the macro is undefined, the ports and logic are absent and the arbitration behaviour is identical.

Test Plan:
- Core-only stream: core read 0x0010 then write 0x0018 (data 0xA5, mask 0xFF), slave ready = 1 → both pass in 2 cycles; responses return to core; dma_rsp_valid stays 0.
- Both valid continuously, slave always ready, STARVE_MAX = 8 → core gets 8 grants, DMA gets grant 9, then the pattern repeats; starve_cnt returns to 0 after each DMA accept.
- Lock test: DMA granted, slave cmd_ready held 0 for 3 cycles while core asserts valid → DMA stays granted and addr stable; core accepted in the cycle after the DMA handshake.
- Outstanding limit, OTF_DEPTH = 2: core then DMA accepted with responses withheld → third command blocked (cmd_ready = 0). Release responses → first routes to core, second to DMA, and a blocked command issues one cycle after the first pop.
- Async reset asserted mid-LOCK with 1 outstanding → all valid/ready 0 immediately, count = 0, state = ARB; after release the first command proceeds normally.
- With DMA_ITCM_ARB_STAT_EN: 5 core + 3 DMA accepts including 4 both-valid cycles → counts 5/3/4; pulse stat_clr → all 0 next cycle.

Source files
------------

// File: rtl/dma_itcm_icb_arbiter.sv
// Two-master ICB arbiter sharing the ITCM slave between the core and the DMA engine.
// Optional statistics counters are enabled with `define DMA_ITCM_ARB_STAT_EN.
module dma_itcm_icb_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 64,
    parameter int OTF_DEPTH  = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            core_icb_cmd_valid,
    output logic            core_icb_cmd_ready,
    input  logic [AW-1:0]   core_icb_cmd_addr,
    input  logic            core_icb_cmd_read,
    input  logic [DW-1:0]   core_icb_cmd_wdata,
    input  logic [DW/8-1:0] core_icb_cmd_wmask,
    output logic            core_icb_rsp_valid,
    input  logic            core_icb_rsp_ready,
    output logic            core_icb_rsp_err,
    output logic [DW-1:0]   core_icb_rsp_rdata,

    input  logic            dma_icb_cmd_valid,
    output logic            dma_icb_cmd_ready,
    input  logic [AW-1:0]   dma_icb_cmd_addr,
    input  logic            dma_icb_cmd_read,
    input  logic [DW-1:0]   dma_icb_cmd_wdata,
    input  logic [DW/8-1:0] dma_icb_cmd_wmask,
    output logic            dma_icb_rsp_valid,
    input  logic            dma_icb_rsp_ready,
    output logic            dma_icb_rsp_err,
    output logic [DW-1:0]   dma_icb_rsp_rdata,

    output logic            itcm_icb_cmd_valid,
    input  logic            itcm_icb_cmd_ready,
    output logic [AW-1:0]   itcm_icb_cmd_addr,
    output logic            itcm_icb_cmd_read,
    output logic [DW-1:0]   itcm_icb_cmd_wdata,
    output logic [DW/8-1:0] itcm_icb_cmd_wmask,
    input  logic            itcm_icb_rsp_valid,
    output logic            itcm_icb_rsp_ready,
    input  logic            itcm_icb_rsp_err,
    input  logic [DW-1:0]   itcm_icb_rsp_rdata
`ifdef DMA_ITCM_ARB_STAT_EN
    ,
    input  logic            stat_clr,
    output logic [31:0]     stat_core_cnt,
    output logic [31:0]     stat_dma_cnt,
    output logic [31:0]     stat_conflict_cnt
`endif
);

    localparam int PW = (OTF_DEPTH > 1) ? $clog2(OTF_DEPTH) : 1;
    localparam int CW = $clog2(OTF_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            lock_id;
    logic [SW-1:0]   starve_cnt;
    logic            fifo_id [OTF_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic            grant;       // 0 = core, 1 = DMA
    logic            gnt_valid;
    logic            fifo_full, fifo_empty;
    logic            cmd_open, rsp_route, head_id;
    logic            cmd_hsk, rsp_hsk, starve_hit;

    assign fifo_full  = (count == CW'(OTF_DEPTH));
    assign fifo_empty = (count == '0);
    assign starve_hit = (starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        if (state_q == LOCK)
            grant = lock_id;
        else
            grant = dma_icb_cmd_valid && (!core_icb_cmd_valid || starve_hit);
    end

    // Outputs are qualified by rst_n so every valid/ready is low while reset is held.
    assign gnt_valid          = grant ? dma_icb_cmd_valid : core_icb_cmd_valid;
    assign cmd_open           = rst_n && !fifo_full;
    assign itcm_icb_cmd_valid = cmd_open && gnt_valid;
    assign core_icb_cmd_ready = cmd_open && !grant && itcm_icb_cmd_ready;
    assign dma_icb_cmd_ready  = cmd_open &&  grant && itcm_icb_cmd_ready;
    assign itcm_icb_cmd_addr  = grant ? dma_icb_cmd_addr  : core_icb_cmd_addr;
    assign itcm_icb_cmd_read  = grant ? dma_icb_cmd_read  : core_icb_cmd_read;
    assign itcm_icb_cmd_wdata = grant ? dma_icb_cmd_wdata : core_icb_cmd_wdata;
    assign itcm_icb_cmd_wmask = grant ? dma_icb_cmd_wmask : core_icb_cmd_wmask;
    assign cmd_hsk            = itcm_icb_cmd_valid && itcm_icb_cmd_ready;

    assign head_id            = fifo_id[rd_ptr];
    assign rsp_route          = rst_n && !fifo_empty;
    assign itcm_icb_rsp_ready = rsp_route && (head_id ? dma_icb_rsp_ready : core_icb_rsp_ready);
    assign core_icb_rsp_valid = rsp_route && !head_id && itcm_icb_rsp_valid;
    assign dma_icb_rsp_valid  = rsp_route &&  head_id && itcm_icb_rsp_valid;
    assign core_icb_rsp_err   = rsp_route && !head_id && itcm_icb_rsp_err;
    assign dma_icb_rsp_err    = rsp_route &&  head_id && itcm_icb_rsp_err;
    assign core_icb_rsp_rdata = (rsp_route && !head_id) ? itcm_icb_rsp_rdata : '0;
    assign dma_icb_rsp_rdata  = (rsp_route &&  head_id) ? itcm_icb_rsp_rdata : '0;
    assign rsp_hsk            = itcm_icb_rsp_valid && itcm_icb_rsp_ready;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (itcm_icb_cmd_valid && !itcm_icb_cmd_ready) state_d = LOCK;
            LOCK:    if (cmd_hsk) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            lock_id    <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB && state_d == LOCK)
                lock_id <= grant;
            if (!dma_icb_cmd_valid || (cmd_hsk && grant))
                starve_cnt <= '0;
            else if (!starve_hit)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (cmd_hsk)
                wr_ptr <= (wr_ptr == PW'(OTF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rsp_hsk)
                rd_ptr <= (rd_ptr == PW'(OTF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (cmd_hsk && !rsp_hsk)
                count <= count + 1'b1;
            else if (rsp_hsk && !cmd_hsk)
                count <= count - 1'b1;
        end
    end

    // NOTE: ID storage has no reset; entries are only read while count says they are valid.
    always_ff @(posedge clk) begin
        if (cmd_hsk)
            fifo_id[wr_ptr] <= grant;
    end

`ifdef DMA_ITCM_ARB_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_core_cnt     <= '0;
            stat_dma_cnt      <= '0;
            stat_conflict_cnt <= '0;
        end else if (stat_clr) begin
            stat_core_cnt     <= '0;
            stat_dma_cnt      <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (cmd_hsk && !grant)
                stat_core_cnt <= stat_core_cnt + 32'd1;
            if (cmd_hsk && grant)
                stat_dma_cnt <= stat_dma_cnt + 32'd1;
            if (core_icb_cmd_valid && dma_icb_cmd_valid)
                stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule
